// File: rtl/load_store_unit_pkg.sv
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Operation encodings and request-classification helpers for
//               the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package load_store_unit_pkg;

    typedef enum logic [2:0] {
        LSU_OP_LB  = 3'd0,
        LSU_OP_LH  = 3'd1,
        LSU_OP_LW  = 3'd2,
        LSU_OP_LBU = 3'd3,
        LSU_OP_LHU = 3'd4,
        LSU_OP_SB  = 3'd5,
        LSU_OP_SH  = 3'd6,
        LSU_OP_SW  = 3'd7
    } lsu_op_e;

    function automatic logic lsu_is_store(input lsu_op_e op);
        return (op >= LSU_OP_SB);
    endfunction

    // Unknown encodings are rejected the same way as misaligned accesses.
    function automatic logic lsu_misaligned(input lsu_op_e op, input logic [1:0] off);
        logic bad;
        case (op)
            LSU_OP_LB, LSU_OP_LBU, LSU_OP_SB: bad = 1'b0;
            LSU_OP_LH, LSU_OP_LHU, LSU_OP_SH: bad = off[0];
            LSU_OP_LW, LSU_OP_SW:             bad = |off;
            default:                          bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// ============================================================================
// Module      : lsu_align
// Description : Big-endian byte/halfword extraction with sign/zero extension,
//               and read-modify-write merge for sub-word stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import load_store_unit_pkg::*;
(
    input  lsu_op_e     op,
    input  logic [1:0]  offset,
    input  logic [31:0] rword,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte    = 8'h00;
        w_half    = offset[1] ? rword[15:0] : rword[31:16];
        load_data = rword;
        merged    = rword;

        // Offset 0 is the most significant byte.
        case (offset)
            2'd0:    w_byte = rword[31:24];
            2'd1:    w_byte = rword[23:16];
            2'd2:    w_byte = rword[15:8];
            default: w_byte = rword[7:0];
        endcase

        case (op)
            LSU_OP_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            LSU_OP_LBU: load_data = {24'h0, w_byte};
            LSU_OP_LH:  load_data = {{16{w_half[15]}}, w_half};
            LSU_OP_LHU: load_data = {16'h0, w_half};
            default:    load_data = rword;
        endcase

        if (op == LSU_OP_SB) begin
            case (offset)
                2'd0:    merged[31:24] = wdata[7:0];
                2'd1:    merged[23:16] = wdata[7:0];
                2'd2:    merged[15:8]  = wdata[7:0];
                default: merged[7:0]   = wdata[7:0];
            endcase
        end else if (op == LSU_OP_SH) begin
            if (offset[1]) merged[15:0]  = wdata;
            else           merged[31:16] = wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store initiator for the data memory.
//               Optional macro LSU_BOUNDS_CHECK_EN rejects addresses beyond
//               the memory instead of wrapping them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int         c_AW       = $clog2(MEM_WORDS);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RD    = 2'd1;
    localparam logic [1:0] c_ST_WR    = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]  r_state;
    lsu_op_e     r_op;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata;

    lsu_op_e     w_op;
    logic        w_reject;
    logic [31:0] w_load;
    logic [31:0] w_merged;
    logic        w_unused_addr;

    assign w_op          = lsu_op_e'(req_op);
    assign w_unused_addr = ^req_addr[31:c_AW+2];

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic [32:0] c_ADDR_LIMIT = 33'(MEM_WORDS) << 2;
    assign w_reject = lsu_misaligned(w_op, req_addr[1:0]) ||
                      ({1'b0, req_addr} >= c_ADDR_LIMIT);
`else
    assign w_reject = lsu_misaligned(w_op, req_addr[1:0]);
`endif

    lsu_align u_align (
        .op        (r_op),
        .offset    (r_offset),
        .rword     (mem_read_data),
        .wdata     (r_wdata),
        .load_data (w_load),
        .merged    (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_IDLE;
            r_op           <= LSU_OP_LB;
            r_offset       <= 2'd0;
            r_wdata        <= 16'h0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= 32'h0;
            mem_write_data <= 32'h0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_op        <= w_op;
                        r_offset    <= req_addr[1:0];
                        r_wdata     <= req_wdata[15:0];
                        mem_address <= 32'(req_addr[c_AW+1:2]);
                        req_ready   <= 1'b0;
                        if (w_reject) begin
                            r_state    <= c_ST_DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else if (w_op == LSU_OP_SW) begin
                            r_state        <= c_ST_WR;
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            r_state  <= c_ST_RD;
                            mem_read <= 1'b1;
                        end
                    end
                end
                // Read word is valid here; sub-word stores merge into it.
                c_ST_RD: begin
                    mem_read <= 1'b0;
                    if (lsu_is_store(r_op)) begin
                        r_state        <= c_ST_WR;
                        mem_write      <= 1'b1;
                        mem_write_data <= w_merged;
                    end else begin
                        r_state    <= c_ST_DONE;
                        resp_valid <= 1'b1;
                        resp_rdata <= w_load;
                    end
                end
                c_ST_WR: begin
                    mem_write  <= 1'b0;
                    r_state    <= c_ST_DONE;
                    resp_valid <= 1'b1;
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
